// File: rtl/ex_div.sv
// ex_div: iterative 32-step restoring divider for the EX stage.
// Handles DIV (signed, truncating) and DIVU by dividing operand magnitudes and
// then fixing up the signs. The result is presented for one cycle in END.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | waiting for div_start; operands are sampled only here
// BY_ZERO | divisor was zero; one cycle, then END with a zero result
// ON      | one shift-subtract step per cycle, 32 steps in total
// END     | div_ready=1 with div_result valid for one cycle, then IDLE
module ex_div #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 div_start,
  input  logic                 div_signed,
  input  logic [WIDTH-1:0]     div_opdata1,
  input  logic [WIDTH-1:0]     div_opdata2,
  input  logic                 div_cancel,
  output logic [2*WIDTH-1:0]   div_result,
  output logic                 div_ready,
  output logic                 stallreq_for_div
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BY_ZERO = 2'd1,
    ON      = 2'd2,
    END     = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  // {remainder[WIDTH:0], quotient[WIDTH-1:0]}; the extra remainder bit
  // catches the shifted-out MSB before the trial subtraction.
  logic [2*WIDTH:0]   work_q, work_d;
  logic [WIDTH-1:0]   dvsr_q, dvsr_d;
  logic               sgn_q, sgn_d;
  logic               neg_quot_q, neg_quot_d;
  logic               neg_rem_q, neg_rem_d;

  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [2*WIDTH:0]   shifted;
  logic [WIDTH+1:0]   diff;
  logic [2*WIDTH:0]   step;
  logic [WIDTH-1:0]   quot_mag, rem_mag;

  // Operand magnitudes; two's-complement negation maps 0x80000000 to itself,
  // which is exactly its unsigned magnitude.
  assign a_neg = div_signed & div_opdata1[WIDTH-1];
  assign b_neg = div_signed & div_opdata2[WIDTH-1];
  assign a_mag = a_neg ? -div_opdata1 : div_opdata1;
  assign b_mag = b_neg ? -div_opdata2 : div_opdata2;

  // One restoring step: shift left, try to subtract the divisor, keep the
  // difference and set the quotient bit only when it does not go negative.
  assign shifted = {work_q[2*WIDTH-1:0], 1'b0};
  assign diff    = {1'b0, shifted[2*WIDTH:WIDTH]} - {2'b00, dvsr_q};
  assign step    = diff[WIDTH+1] ? shifted
                                 : {diff[WIDTH:0], shifted[WIDTH-1:1], 1'b1};

  assign quot_mag = work_q[WIDTH-1:0];
  assign rem_mag  = work_q[2*WIDTH-1:WIDTH];

  // State, counter, working register and latched operand info.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      work_q     <= '0;
      dvsr_q     <= '0;
      sgn_q      <= 1'b0;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      work_q     <= work_d;
      dvsr_q     <= dvsr_d;
      sgn_q      <= sgn_d;
      neg_quot_q <= neg_quot_d;
      neg_rem_q  <= neg_rem_d;
    end
  end

  // Next-state and datapath update; cancel aborts work in progress only.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    work_d     = work_q;
    dvsr_d     = dvsr_q;
    sgn_d      = sgn_q;
    neg_quot_d = neg_quot_q;
    neg_rem_d  = neg_rem_q;
    case (state_q)
      IDLE: begin
        if (div_start && !div_cancel) begin
          cnt_d      = '0;
          sgn_d      = div_signed;
          neg_quot_d = a_neg ^ b_neg;
          neg_rem_d  = a_neg;
          work_d     = {{(WIDTH+1){1'b0}}, a_mag};
          dvsr_d     = b_mag;
          state_d    = (div_opdata2 == '0) ? BY_ZERO : ON;
        end
      end
      BY_ZERO: begin
        if (div_cancel) begin
          state_d = IDLE;
        end else begin
          work_d  = '0;
          state_d = END;
        end
      end
      ON: begin
        if (div_cancel) begin
          state_d = IDLE;
        end else begin
          work_d = step;
          cnt_d  = cnt_q + 1'b1;
          if (cnt_q == CW'(WIDTH - 1)) begin
            state_d = END;
          end
        end
      end
      END: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Result is only visible in END; elsewhere the outputs are held at zero.
  always_comb begin
    div_ready  = 1'b0;
    div_result = '0;
    if (state_q == END) begin
      div_ready                    = 1'b1;
      div_result[WIDTH-1:0]        = (sgn_q && neg_quot_q) ? -quot_mag : quot_mag;
      div_result[2*WIDTH-1:WIDTH]  = (sgn_q && neg_rem_q) ? -rem_mag : rem_mag;
    end
  end

  assign stallreq_for_div = div_start & ~div_ready;

endmodule

// File: tb/tb_ex_div.sv
// tb_ex_div: directed and randomized checks of ex_div against an
// arithmetic reference (64-bit integer division) with a cycle timeline model.
module tb_ex_div;

  logic        clk = 1'b0;
  logic        rst;
  logic        div_start;
  logic        div_signed;
  logic [31:0] op1;
  logic [31:0] op2;
  logic        div_cancel;
  logic [63:0] div_result;
  logic        div_ready;
  logic        stallreq;

  int vectors    = 0;
  int miscompares = 0;
  bit chk_en     = 1'b0;

  // Timeline model: busy with an operation whose result appears after
  // m_left more cycles.
  bit          m_busy = 1'b0;
  int          m_left = 0;
  logic [63:0] m_res  = '0;

  ex_div #(.WIDTH(32)) dut (
    .clk              (clk),
    .rst              (rst),
    .div_start        (div_start),
    .div_signed       (div_signed),
    .div_opdata1      (op1),
    .div_opdata2      (op2),
    .div_cancel       (div_cancel),
    .div_result       (div_result),
    .div_ready        (div_ready),
    .stallreq_for_div (stallreq)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] ref_div(logic [31:0] a, logic [31:0] b, logic s);
    longint sa, sb, q, r;
    if (b == 32'd0) return 64'd0;
    if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'd0, a});
      sb = longint'({32'd0, b});
    end
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0:       return 32'd0;
      1:       return 32'd1;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_loop();
    logic        exp_rdy;
    logic [63:0] exp_res;
    forever begin
      @(negedge clk);
      if (chk_en) begin
        exp_rdy = m_busy && (m_left == 0);
        exp_res = exp_rdy ? m_res : 64'd0;
        check("ready",  {63'd0, div_ready}, {63'd0, exp_rdy});
        check("result", div_result, exp_res);
        check("stall",  {63'd0, stallreq}, {63'd0, div_start & ~exp_rdy});
        if (rst) begin
          m_busy = 1'b0;
        end else if (m_busy) begin
          if (m_left == 0)     m_busy = 1'b0;
          else if (div_cancel) m_busy = 1'b0;
          else                 m_left--;
        end else if (div_start && !div_cancel) begin
          m_busy = 1'b1;
          m_left = (op2 == 32'd0) ? 1 : 32;
          m_res  = ref_div(op1, op2, div_signed);
        end
      end
    end
  endtask

  // Starts one operation; lat is the cycle of div_ready counted from the
  // start cycle, or -1 if none was seen.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                        input int cancel_at, input int rst_at, input bit scramble,
                        input bit hold, output logic [63:0] res, output int lat);
    int stop_at;
    stop_at = (cancel_at >= 0) ? cancel_at + 3 : ((rst_at >= 0) ? rst_at + 3 : 40);
    @(posedge clk); #1;
    div_start  = 1'b1;
    div_signed = s;
    op1        = a;
    op2        = b;
    lat        = -1;
    res        = '0;
    for (int c = 0; c <= stop_at; c++) begin
      @(negedge clk);
      if (div_ready) begin
        lat = c;
        res = div_result;
        break;
      end
      if (c == stop_at) break;
      @(posedge clk); #1;
      if (c + 1 == cancel_at) div_cancel = 1'b1;
      if (c + 1 == rst_at)    rst = 1'b1;
      if (c == cancel_at || c == rst_at) begin
        div_cancel = 1'b0;
        rst        = 1'b0;
        div_start  = 1'b0;
      end
      if (scramble && div_start) begin
        op1        = $urandom;
        op2        = $urandom;
        div_signed = 1'($urandom_range(0, 1));
      end
    end
    if (!hold) begin
      @(posedge clk); #1;
      div_start  = 1'b0;
      div_cancel = 1'b0;
      rst        = 1'b0;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] res;
    int          lat;
    logic [31:0] a, b;
    logic        s;
    int          ca, ra;

    rst        = 1'b1;
    div_start  = 1'b0;
    div_signed = 1'b0;
    div_cancel = 1'b0;
    op1        = '0;
    op2        = '0;
    fork
      model_loop();
    join_none

    repeat (2) @(posedge clk);
    #1 chk_en = 1'b1;
    // Reset must win over start and cancel.
    div_start  = 1'b1;
    div_cancel = 1'b1;
    op1 = 32'd5; op2 = 32'd1;
    @(negedge clk);
    check("reset_ready",  {63'd0, div_ready}, 64'd0);
    check("reset_result", div_result, 64'd0);
    @(posedge clk); #1;
    div_start  = 1'b0;
    div_cancel = 1'b0;
    rst        = 1'b0;

    check("model_pin_divu", ref_div(32'd7, 32'd2, 1'b0), {32'd1, 32'd3});
    check("model_pin_div",  ref_div(32'hFFFF_FFF9, 32'd2, 1'b1), {32'hFFFF_FFFF, 32'hFFFF_FFFD});

    run_op(32'd7, 32'd2, 1'b0, -1, -1, 1'b0, 1'b0, res, lat);
    check("divu_7_2", res, {32'h1, 32'h3});
    check("lat_7_2", 64'(lat), 64'd33);

    run_op(32'hFFFF_FFF9, 32'd2, 1'b1, -1, -1, 1'b1, 1'b0, res, lat);
    check("div_m7_2", res, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    run_op(32'd7, 32'hFFFF_FFFE, 1'b1, -1, -1, 1'b0, 1'b0, res, lat);
    check("div_7_m2", res, {32'h1, 32'hFFFF_FFFD});
    run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, -1, -1, 1'b0, 1'b0, res, lat);
    check("div_min_m1", res, {32'h0, 32'h8000_0000});
    run_op(32'hFFFF_FFFF, 32'd1, 1'b0, -1, -1, 1'b0, 1'b0, res, lat);
    check("divu_max_1", res, {32'h0, 32'hFFFF_FFFF});

    run_op(32'h1234_5678, 32'd0, 1'b0, -1, -1, 1'b0, 1'b0, res, lat);
    check("div_by_zero", res, 64'd0);
    check("lat_by_zero", 64'(lat), 64'd2);

    // Back-to-back with start held: second ready 67 cycles after first start.
    run_op(32'd100, 32'd7, 1'b0, -1, -1, 1'b0, 1'b1, res, lat);
    check("b2b_first", res, {32'd2, 32'd14});
    check("b2b_first_lat", 64'(lat), 64'd33);
    run_op(32'd9, 32'd3, 1'b0, -1, -1, 1'b0, 1'b0, res, lat);
    check("b2b_second", res, {32'd0, 32'd3});
    check("b2b_second_lat", 64'(lat), 64'd33);

    run_op(32'd1000, 32'd9, 1'b0, 10, -1, 1'b0, 1'b0, res, lat);
    check("cancel_no_ready", {63'd0, lat == -1}, 64'd1);
    run_op(32'd1000, 32'd9, 1'b0, -1, -1, 1'b0, 1'b0, res, lat);
    check("after_cancel", res, {32'd1, 32'd111});
    check("after_cancel_lat", 64'(lat), 64'd33);

    run_op(32'd1000, 32'd9, 1'b0, -1, 10, 1'b0, 1'b0, res, lat);
    check("rst_no_ready", {63'd0, lat == -1}, 64'd1);
    run_op(32'hFFFF_FC18, 32'd9, 1'b1, -1, -1, 1'b0, 1'b0, res, lat);
    check("after_rst", res, {32'hFFFF_FFFF, 32'hFFFF_FF91});

    // Cancel and start together in IDLE: nothing starts.
    @(posedge clk); #1;
    div_start = 1'b1; div_cancel = 1'b1; op1 = 32'd50; op2 = 32'd5;
    repeat (4) @(negedge clk);
    check("cancel_wins_idle", {63'd0, div_ready}, 64'd0);
    @(posedge clk); #1;
    div_start = 1'b0; div_cancel = 1'b0;

    for (int i = 0; i < 60; i++) begin
      a  = pick();
      b  = pick();
      s  = 1'($urandom_range(0, 1));
      ca = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 32)) : -1;
      ra = (ca < 0 && $urandom_range(0, 14) == 0) ? int'($urandom_range(1, 32)) : -1;
      run_op(a, b, s, ca, ra, 1'($urandom_range(0, 1)), 1'b0, res, lat);
      if (ca < 0 && ra < 0) begin
        check("rand_result", res, ref_div(a, b, s));
        check("rand_lat", 64'(lat), (b == 32'd0) ? 64'd2 : 64'd33);
      end
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ex_div.md
EX_DIV -- requirements
Module: ex_div

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, meaning operand width in bits; only 32 is required to be supported.
REQ-002 The block SHALL have port clk  input  1  pipeline clock, all state updates on rising edge.
REQ-003 The block SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 The block SHALL have port div_start  input  1  EX requests a divide; held high by EX while the instruction is stalled in EX.
REQ-005 The block SHALL have port div_signed  input  1  1 = DIV (two's complement), 0 = DIVU.
REQ-006 The block SHALL have port div_opdata1  input  32  dividend (rs).
REQ-007 The block SHALL have port div_opdata2  input  32  divisor (rt).
REQ-008 The block SHALL have port div_cancel  input  1  abort the operation in flight (pipeline flush).
REQ-009 The block SHALL have port div_result  output  64  {remainder[63:32] -> HI, quotient[31:0] -> LO}, packed by EX into the 66-bit hilo bus to MEM.
REQ-010 The block SHALL have port div_ready  output  1  div_result valid this cycle.
REQ-011 The block SHALL have port stallreq_for_div  output  1  stall request to the stall controller.

Function
REQ-012 The block SHALL implement FSM states IDLE, BY_ZERO, ON, END.
REQ-013 IDLE: on div_start=1 and div_cancel=0, the block SHALL latch div_signed, latch |opdata1| and |opdata2| (magnitudes only when div_signed=1, raw values otherwise), clear the iteration counter, and go to BY_ZERO if div_opdata2==0, else to ON.
REQ-014 Operands SHALL be sampled only in IDLE; changes on the operand inputs during ON SHALL have no effect.
REQ-015 ON: each cycle the block SHALL perform one restoring shift-subtract step on a 65-bit working register (remainder:quotient); the counter SHALL increment.
REQ-016 ON SHALL last exactly 32 cycles; after the 32nd step the block SHALL go to END.
REQ-017 BY_ZERO: the block SHALL go to END after one cycle with quotient=0 and remainder=0.
REQ-018 Signed fix-up: the quotient SHALL be negated when dividend and divisor signs differ; the remainder SHALL take the dividend's sign (MIPS truncating division).
REQ-019 Magnitude of 0x80000000 SHALL be treated as unsigned 0x80000000; no overflow trap is raised.
REQ-020 END: the block SHALL drive div_ready=1 and div_result for exactly one cycle, then return to IDLE unconditionally.
REQ-021 Outside END, div_ready SHALL be 0 and div_result SHALL be 0.
REQ-022 stallreq_for_div SHALL be combinational: div_start AND NOT div_ready.
REQ-023 Latency: div_start seen in IDLE at cycle 0 SHALL give div_ready at cycle 33 (divisor non-zero) or cycle 2 (divisor zero).
REQ-024 A new div_start seen in the IDLE cycle right after END SHALL begin a new operation (back-to-back divides).
REQ-025 div_cancel=1 in ON or BY_ZERO SHALL return the FSM to IDLE next cycle with no div_ready pulse; div_cancel in END SHALL be ignored; div_cancel in IDLE SHALL block starting.
REQ-026 If div_cancel and div_start are both 1 in IDLE, cancel SHALL win.

Reset
REQ-027 With rst=1 at a rising edge, the block SHALL enter IDLE, clear counter and working register, and drive div_ready=0, div_result=0.
REQ-028 Reset SHALL take priority over div_start and div_cancel, including reset in the middle of ON, with no div_ready pulse afterwards.
REQ-029 The first operation after reset release SHALL behave identically to any other operation.

Verification
REQ-030 DIVU 7/2, start held -> div_ready at cycle 33, div_result = {0x00000001, 0x00000003}; stallreq 1 in cycles 0-32, 0 in cycle 33.
REQ-031 DIV 0xFFFFFFF9 (-7) / 2 -> div_result = {0xFFFFFFFF, 0xFFFFFFFD}; DIV 7 / 0xFFFFFFFE -> {0x00000001, 0xFFFFFFFD}.
REQ-032 DIV 0x80000000 / 0xFFFFFFFF -> {0x00000000, 0x80000000}; DIVU 0xFFFFFFFF / 1 -> {0x00000000, 0xFFFFFFFF}.
REQ-033 Divisor 0, dividend 0x12345678 -> div_ready at cycle 2, div_result = 0.
REQ-034 div_cancel at cycle 10 of ON -> IDLE next cycle, no div_ready. A new start then gives correct result 33 cycles later. Repeat with rst pulsed at cycle 10: same required outcome.
REQ-035 Back-to-back: DIVU 100/7 then DIVU 9/3, start high throughout -> results {2,14} at cycle 33, {0,3} at cycle 67.
